// File: rtl/w1_wmem_pkg.sv
// Shared weight-memory package: geometry, load counter width and the load FSM
// state encoding. The weight consumer imports this package as well.
package w1_wmem_pkg;

  localparam int WMEM_NBANK = 16;   // banks, one per read port
  localparam int WMEM_DEPTH = 16;   // entries per bank
  localparam int WMEM_DW    = 8;    // signed weight width
  localparam int WMEM_AW    = 4;    // entry address width
  localparam int WMEM_KW    = 8;    // load byte counter width
  localparam int WMEM_NBYTE = WMEM_NBANK * WMEM_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } wmem_state_t;

endpackage

// File: rtl/w1_wmem_bank.sv
// One weight bank: DEPTH x DW storage, single write port and a single
// registered read port. Reads return the value held before a same-cycle write.
module w1_wmem_bank #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [DW-1:0] rdata
);

  logic signed [DW-1:0] mem [DEPTH];

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; only the output register is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/w1_wmem.sv
// Weight memory: NBANK parallel banks with one registered read port each and
// a byte-serial loader that fills all banks address-major.
// Optional feature macro: WMEM_LOAD_CHECKSUM_EN adds the ld_csum output.
//
// Load handshake: ld_ready is high exactly while the loader is in LOAD. A byte
// on ld_data transfers on any rising edge where ld_valid && ld_ready and xrst
// is low; ld_valid may be dropped or raised freely, and a continuously high
// ld_valid moves one byte per cycle with no bubbles.
module w1_wmem
  import w1_wmem_pkg::*;
#(
  parameter int NBANK = WMEM_NBANK,
  parameter int DEPTH = WMEM_DEPTH,
  parameter int DW    = WMEM_DW
) (
  input  logic                   clk,
  input  logic                   xrst,
  input  logic [WMEM_AW-1:0]     w0_raddr,
  input  logic [WMEM_AW-1:0]     w1_raddr,
  input  logic [WMEM_AW-1:0]     w2_raddr,
  input  logic [WMEM_AW-1:0]     w3_raddr,
  input  logic [WMEM_AW-1:0]     w4_raddr,
  input  logic [WMEM_AW-1:0]     w5_raddr,
  input  logic [WMEM_AW-1:0]     w6_raddr,
  input  logic [WMEM_AW-1:0]     w7_raddr,
  input  logic [WMEM_AW-1:0]     w8_raddr,
  input  logic [WMEM_AW-1:0]     w9_raddr,
  input  logic [WMEM_AW-1:0]     w10_raddr,
  input  logic [WMEM_AW-1:0]     w11_raddr,
  input  logic [WMEM_AW-1:0]     w12_raddr,
  input  logic [WMEM_AW-1:0]     w13_raddr,
  input  logic [WMEM_AW-1:0]     w14_raddr,
  input  logic [WMEM_AW-1:0]     w15_raddr,
  output logic signed [DW-1:0]   w0_rdata,
  output logic signed [DW-1:0]   w1_rdata,
  output logic signed [DW-1:0]   w2_rdata,
  output logic signed [DW-1:0]   w3_rdata,
  output logic signed [DW-1:0]   w4_rdata,
  output logic signed [DW-1:0]   w5_rdata,
  output logic signed [DW-1:0]   w6_rdata,
  output logic signed [DW-1:0]   w7_rdata,
  output logic signed [DW-1:0]   w8_rdata,
  output logic signed [DW-1:0]   w9_rdata,
  output logic signed [DW-1:0]   w10_rdata,
  output logic signed [DW-1:0]   w11_rdata,
  output logic signed [DW-1:0]   w12_rdata,
  output logic signed [DW-1:0]   w13_rdata,
  output logic signed [DW-1:0]   w14_rdata,
  output logic signed [DW-1:0]   w15_rdata,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic signed [DW-1:0]   ld_data,
  output logic                   ld_ready,
  output logic                   ld_done,
  output logic                   wmem_valid,
  output wmem_state_t            state
`ifdef WMEM_LOAD_CHECKSUM_EN
  ,
  output logic [15:0]            ld_csum
`endif
);

  logic [WMEM_AW-1:0]   raddr [NBANK];
  logic signed [DW-1:0] rdata [NBANK];
  logic [WMEM_KW-1:0]   k;
  logic                 xfer;

  // A transfer only counts when reset is not also asserted.
  assign xfer = ld_valid && ld_ready && !xrst;

  assign raddr[0]  = w0_raddr;
  assign raddr[1]  = w1_raddr;
  assign raddr[2]  = w2_raddr;
  assign raddr[3]  = w3_raddr;
  assign raddr[4]  = w4_raddr;
  assign raddr[5]  = w5_raddr;
  assign raddr[6]  = w6_raddr;
  assign raddr[7]  = w7_raddr;
  assign raddr[8]  = w8_raddr;
  assign raddr[9]  = w9_raddr;
  assign raddr[10] = w10_raddr;
  assign raddr[11] = w11_raddr;
  assign raddr[12] = w12_raddr;
  assign raddr[13] = w13_raddr;
  assign raddr[14] = w14_raddr;
  assign raddr[15] = w15_raddr;

  assign w0_rdata  = rdata[0];
  assign w1_rdata  = rdata[1];
  assign w2_rdata  = rdata[2];
  assign w3_rdata  = rdata[3];
  assign w4_rdata  = rdata[4];
  assign w5_rdata  = rdata[5];
  assign w6_rdata  = rdata[6];
  assign w7_rdata  = rdata[7];
  assign w8_rdata  = rdata[8];
  assign w9_rdata  = rdata[9];
  assign w10_rdata = rdata[10];
  assign w11_rdata = rdata[11];
  assign w12_rdata = rdata[12];
  assign w13_rdata = rdata[13];
  assign w14_rdata = rdata[14];
  assign w15_rdata = rdata[15];

  // Byte k lands in bank k[3:0], entry k[7:4]: 16 consecutive bytes fill one
  // address across every bank.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    localparam logic [3:0] BIDX = 4'(b);
    w1_wmem_bank #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .AW    (WMEM_AW)
    ) u_bank (
      .clk   (clk),
      .rst   (xrst),
      .we    (xfer && (k[3:0] == BIDX)),
      .waddr (k[7:4]),
      .wdata (ld_data),
      .raddr (raddr[b]),
      .rdata (rdata[b])
    );
  end

  // Loader FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (xrst) begin
      state      <= ST_IDLE;
      k          <= '0;
      ld_ready   <= 1'b0;
      ld_done    <= 1'b0;
      wmem_valid <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ld_start) begin
            state      <= ST_LOAD;
            k          <= '0;
            ld_ready   <= 1'b1;
            wmem_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            k <= k + 8'd1;
            if (k == 8'hFF) begin
              state      <= ST_DONE;
              ld_ready   <= 1'b0;
              ld_done    <= 1'b1;
              wmem_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef WMEM_LOAD_CHECKSUM_EN
  // Running modulo-2^16 sum of sign-extended accepted bytes; frozen once the
  // last byte is in because no further transfers are possible until restart.
  always_ff @(posedge clk) begin
    if (xrst)                              ld_csum <= '0;
    else if (state == ST_IDLE && ld_start) ld_csum <= '0;
    else if (xfer)                         ld_csum <= ld_csum + 16'(ld_data);
  end
`endif

endmodule

// File: tb/tb_w1_wmem.sv
// Bench for w1_wmem: random loads and random parallel reads checked against a
// bank/entry array model; read results flow through an expected-value queue.
module tb_w1_wmem;
  import w1_wmem_pkg::*;

  logic              clk;
  logic              xrst;
  logic [3:0]        ra [16];
  logic signed [7:0] rd [16];
  logic              ld_start;
  logic              ld_valid;
  logic signed [7:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              wmem_valid;
  wmem_state_t       state;
`ifdef WMEM_LOAD_CHECKSUM_EN
  logic [15:0]       ld_csum;
`endif

  // Reference model and scoreboard
  logic [7:0]        ref_mem [16][16];   // [bank][entry]
  logic signed [7:0] bytes [256];
  logic [15:0]       csum_model;
  logic [7:0]        exp_q [$];
  logic              rd_req;
  logic              pend;
  int                n_cmp;
  int                n_bad;
  int                done_cnt;

  w1_wmem dut (
    .clk (clk), .xrst (xrst),
    .w0_raddr (ra[0]),   .w1_raddr (ra[1]),   .w2_raddr (ra[2]),   .w3_raddr (ra[3]),
    .w4_raddr (ra[4]),   .w5_raddr (ra[5]),   .w6_raddr (ra[6]),   .w7_raddr (ra[7]),
    .w8_raddr (ra[8]),   .w9_raddr (ra[9]),   .w10_raddr (ra[10]), .w11_raddr (ra[11]),
    .w12_raddr (ra[12]), .w13_raddr (ra[13]), .w14_raddr (ra[14]), .w15_raddr (ra[15]),
    .w0_rdata (rd[0]),   .w1_rdata (rd[1]),   .w2_rdata (rd[2]),   .w3_rdata (rd[3]),
    .w4_rdata (rd[4]),   .w5_rdata (rd[5]),   .w6_rdata (rd[6]),   .w7_rdata (rd[7]),
    .w8_rdata (rd[8]),   .w9_rdata (rd[9]),   .w10_rdata (rd[10]), .w11_rdata (rd[11]),
    .w12_rdata (rd[12]), .w13_rdata (rd[13]), .w14_rdata (rd[14]), .w15_rdata (rd[15]),
    .ld_start (ld_start), .ld_valid (ld_valid), .ld_data (ld_data),
    .ld_ready (ld_ready), .ld_done (ld_done), .wmem_valid (wmem_valid),
    .state (state)
`ifdef WMEM_LOAD_CHECKSUM_EN
    , .ld_csum (ld_csum)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: reads issued before an edge are presented just after that edge.
  always @(posedge clk) begin
    pend = rd_req;
    #1;
    if (pend) begin
      for (int b = 0; b < 16; b++) begin
        logic [7:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_queue_empty bank %0d: got %0d required queued value", b, rd[b]);
        end else begin
          e = exp_q.pop_front();
          if (rd[b] !== e) begin
            n_bad++;
            $display("FAIL rdata bank %0d: got %0d required %0d", b, rd[b], $signed(e));
          end
        end
      end
    end
    if (ld_done === 1'b1) done_cnt++;
  end

  // Driver: random addresses on every bank, expectations taken from the model
  // before this cycle's write is applied (read-before-write).
  task automatic drive_reads(input bit on, input bit probe0);
    if (!on) begin
      rd_req = 1'b0;
      return;
    end
    for (int b = 0; b < 16; b++) begin
      ra[b] = 4'($urandom_range(0, 15));
      if (b == 0 && probe0) ra[b] = 4'd0;
      exp_q.push_back(ref_mem[b][ra[b]]);
    end
    rd_req = 1'b1;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      for (int b = 0; b < 16; b++) begin
        ra[b] = 4'(a);
        exp_q.push_back(ref_mem[b][a]);
      end
      rd_req = 1'b1;
    end
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 toggled valid, 2 random valid.
  // n_stop < 256 aborts the load with xrst after that many transfers.
  task automatic run_load(input int gap_mode, input int n_stop, input bit start_mid,
                          input bit done_start, input bit rd_on);
    int  i;
    int  last;
    int  d0;
    logic v;
    d0 = done_cnt;
    csum_model = '0;
    @(negedge clk);
    ld_start = 1'b1;
    drive_reads(1'b0, 1'b0);
    @(negedge clk);
    ld_start = 1'b0;
    check("ld_ready_in_load", ld_ready, 1);
    check("wmem_valid_cleared", wmem_valid, 0);
    check("state_load", state, ST_LOAD);
    i = 0;
    last = -1;
    for (int cyc = 0; cyc < 1500 && i < n_stop; cyc++) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      ld_start = start_mid && (cyc == 60);
      ld_valid = v;
      ld_data  = bytes[i];
      drive_reads(rd_on, i <= 1);
      if (v && ld_ready) begin
        ref_mem[i % 16][i / 16] = bytes[i];
        csum_model = csum_model + 16'(bytes[i]);
        last = cyc;
        i++;
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    drive_reads(1'b0, 1'b0);
    check("transfer_count", i, n_stop);
    if (n_stop == 256) begin
      check("ld_done_pulse", ld_done, 1);
      check("state_done", state, ST_DONE);
      check("wmem_valid_set", wmem_valid, 1);
      check("ld_ready_after_load", ld_ready, 0);
      if (gap_mode == 0) check("no_bubble_last_cycle", last, 255);
`ifdef WMEM_LOAD_CHECKSUM_EN
      check("ld_csum_at_done", ld_csum, csum_model);
`endif
      ld_start = done_start;
      @(negedge clk);
      ld_start = 1'b0;
      check("ld_done_one_cycle", ld_done, 0);
      check("state_idle_after_done", state, ST_IDLE);
      check("wmem_valid_holds", wmem_valid, 1);
      @(negedge clk);
      check("state_idle_stays", state, ST_IDLE);
      check("ld_done_count", done_cnt, d0 + 1);
    end else begin
      xrst = 1'b1;
      @(negedge clk);
      xrst = 1'b0;
      check("abort_state_idle", state, ST_IDLE);
      check("abort_wmem_valid", wmem_valid, 0);
      check("abort_ld_ready", ld_ready, 0);
      check("abort_ld_done_count", done_cnt, d0);
      for (int b = 0; b < 16; b++) check("abort_rdata_zero", rd[b], 0);
`ifdef WMEM_LOAD_CHECKSUM_EN
      check("abort_ld_csum", ld_csum, 0);
`endif
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    done_cnt = 0;
    rd_req = 1'b0;
    ld_valid = 1'b0;
    ld_data = '0;
    for (int b = 0; b < 16; b++) ra[b] = '0;

    // Reset for two cycles, with ld_start asserted alongside to show reset wins.
    xrst = 1'b1;
    ld_start = 1'b1;
    repeat (2) @(negedge clk);
    ld_start = 1'b0;
    xrst = 1'b0;
    for (int b = 0; b < 16; b++) check("reset_rdata", rd[b], 0);
    check("reset_ld_ready", ld_ready, 0);
    check("reset_wmem_valid", wmem_valid, 0);
    check("reset_ld_done", ld_done, 0);
    check("reset_state", state, ST_IDLE);

    // Load A: byte k = k-128, back-to-back; ld_start during DONE is ignored.
    for (int k = 0; k < 256; k++) bytes[k] = 8'(k - 128);
    run_load(0, 256, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    for (int b = 0; b < 16; b++) begin
      ra[b] = 4'd3;
      exp_q.push_back(ref_mem[b][3]);
    end
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("w5_addr3", rd[5], -75);
    read_all();

    // Load B: same bytes, toggled valid, stray ld_start mid-load.
    run_load(1, 256, 1'b1, 1'b0, 1'b1);
    read_all();

    // Load C: random bytes, entry (0,0) = -1, random valid gaps.
    for (int k = 0; k < 256; k++) bytes[k] = 8'($urandom_range(0, 255));
    bytes[0] = -8'sd1;
    run_load(2, 256, 1'b0, 1'b0, 1'b1);
    read_all();

    // Load D: entry (0,0) overwritten with 7 while being read.
    for (int k = 0; k < 256; k++) bytes[k] = 8'($urandom_range(0, 255));
    bytes[0] = 8'sd7;
    run_load(0, 256, 1'b0, 1'b0, 1'b1);
    read_all();

    // Load E: aborted by reset after 100 transfers; partial contents kept.
    for (int k = 0; k < 256; k++) bytes[k] = 8'($urandom_range(0, 255));
    run_load(2, 100, 1'b0, 1'b0, 1'b1);
    read_all();

`ifdef WMEM_LOAD_CHECKSUM_EN
    // Load F: all bytes -1; checksum is 256 * 0xFFFF mod 2^16.
    for (int k = 0; k < 256; k++) bytes[k] = -8'sd1;
    run_load(0, 256, 1'b0, 1'b0, 1'b1);
    check("ld_csum_all_ones", ld_csum, 16'hFF00);
    read_all();
`endif

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
